mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/mul_unit.sv | 180 ++++++++++++++++++
 tb/tb_mul_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multiply unit: operation encodings, FSM state
// encoding, iteration count and datapath widths.
// Optional feature macro: MUL_HIGH_EN (enables MULH/MULHSU/MULHU and a
// 64-bit accumulator; without it every operation is a 32-bit MUL).
package cpu_pkg;

    // Number of shift-add iterations, one multiplier bit per cycle
    localparam int MUL_CYCLES = 32;

    typedef enum logic [1:0] {
        FN_MUL    = 2'd0,
        FN_MULH   = 2'd1,
        FN_MULHSU = 2'd2,
        FN_MULHU  = 2'd3
    } funct_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

`ifdef MUL_HIGH_EN
    // Full 64-bit product; multiplier magnitude needs 33 bits so that
    // -2^31 is representable as a positive value.
    localparam int ACC_W = 64;
    localparam int MPL_W = 33;
`else
    // Only the low product word is ever needed.
    localparam int ACC_W = 32;
    localparam int MPL_W = 32;
`endif

    // Absolute value of a 32-bit operand, widened to 33 bits so that
    // 0x80000000 read as signed yields +2^31 without overflow.
    function automatic logic [32:0] magnitude(input logic [31:0] v,
                                              input logic        is_signed);
        logic [32:0] m;
        if (is_signed && v[31]) begin
            m = ~{1'b1, v} + 33'd1;
        end else begin
            m = {1'b0, v};
        end
        return m;
    endfunction

endpackage

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier with IDLE/CALC/DONE control.
// An accepted operation spends 32 cycles in CALC (one multiplier bit per
// cycle) and then one cycle in DONE, where the writeback strobe is raised.
// Optional feature macro: MUL_HIGH_EN -- when defined, funct selects
// MUL/MULH/MULHSU/MULHU over a 64-bit accumulator; when undefined, funct is
// ignored and every operation is a 32-bit MUL with identical latency.
module mul_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [1:0]  funct,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    output logic        ready,
    output logic [4:0]  busy_rd,
    output logic [31:0] result,
    output logic [4:0]  rd,
    output logic        rd_valid
);

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   mcand_q, mcand_d;
    logic [MPL_W-1:0]   mplier_q, mplier_d;
    logic [4:0]         rd_q, rd_d;
    logic [31:0]        result_q, result_d;

    logic               accept;
    logic               last_iter;
    logic [ACC_W-1:0]   prod_next;
    logic [31:0]        final_word;

`ifdef MUL_HIGH_EN
    logic               neg_q, neg_d;
    logic               high_q, high_d;
    funct_e             fn;
    logic               sign_a, sign_b;
    logic [32:0]        mag_a, mag_b;
    logic [ACC_W-1:0]   prod_fix;
`else
    // funct has no effect in the MUL-only build
    logic               unused_funct;
    assign unused_funct = ^funct;
`endif

    // A new operation starts only when the unit can take it and no flush
    // is killing the pipeline this cycle (flush wins over start).
    assign accept    = start && ready && !flush;
    assign last_iter = (state_q == ST_CALC) && (cnt_q == 6'(MUL_CYCLES - 1));

    // Partial product after the current iteration
    assign prod_next = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MUL_HIGH_EN
    // Operand signedness per operation, magnitudes and final product sign
    assign fn     = funct_e'(funct);
    assign sign_a = (fn == FN_MULH) || (fn == FN_MULHSU);
    assign sign_b = (fn == FN_MULH);
    assign mag_a  = magnitude(op_a, sign_a);
    assign mag_b  = magnitude(op_b, sign_b);

    // Restore the sign of the product and pick the requested word
    assign prod_fix   = neg_q ? (~prod_next + ACC_W'(1)) : prod_next;
    assign final_word = high_q ? prod_fix[63:32] : prod_fix[31:0];
`else
    assign final_word = prod_next;
`endif

    // Next-state logic: flush overrides everything and returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_CALC;
            ST_CALC: if (last_iter) state_d = ST_DONE;
            ST_DONE: state_d = accept ? ST_CALC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // Iteration counter: cleared on acceptance or flush, steps in CALC
    always_comb begin
        cnt_d = cnt_q;
        if (flush || accept) begin
            cnt_d = 6'd0;
        end else if (state_q == ST_CALC) begin
            cnt_d = cnt_q + 6'd1;
        end
    end

    // Datapath: load operands on acceptance, shift-add in CALC, capture
    // the finished word on the last iteration so it is stable in DONE
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rd_d     = rd_q;
        result_d = result_q;
`ifdef MUL_HIGH_EN
        neg_d    = neg_q;
        high_d   = high_q;
`endif
        if (accept) begin
            acc_d    = '0;
            rd_d     = rd_in;
`ifdef MUL_HIGH_EN
            mcand_d  = ACC_W'(mag_a);
            mplier_d = mag_b;
            neg_d    = (sign_a && op_a[31]) ^ (sign_b && op_b[31]);
            high_d   = (fn != FN_MUL);
`else
            mcand_d  = op_a;
            mplier_d = op_b;
`endif
        end else if (state_q == ST_CALC && !flush) begin
            acc_d    = prod_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (last_iter) begin
                result_d = final_word;
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rd_q     <= 5'd0;
            result_q <= 32'd0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rd_q     <= rd_d;
            result_q <= result_d;
        end
    end

`ifdef MUL_HIGH_EN
    // Sign-fix and word-select flags for the in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q  <= 1'b0;
            high_q <= 1'b0;
        end else begin
            neg_q  <= neg_d;
            high_q <= high_d;
        end
    end
`endif

    // Outputs decoded from state; register x0 never gets a strobe
    assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy_rd  = (state_q == ST_CALC) ? rd_q : 5'd0;
    assign rd_valid = (state_q == ST_DONE) && (rd_q != 5'd0);
    assign result   = result_q;
    assign rd       = rd_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed testbench for mul_unit: a table of multiplies with
// hand-computed products, plus sequences for flush, back-to-back issue,
// start-in-CALC, flush-vs-start and mid-operation reset.
module tb_mul_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  funct;
    logic [4:0]  rd_in;
    logic        flush;
    logic        ready;
    logic [4:0]  busy_rd;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rd_valid;

    int checks = 0;
    int errors = 0;

    mul_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .funct    (funct),
        .rd_in    (rd_in),
        .flush    (flush),
        .ready    (ready),
        .busy_rd  (busy_rd),
        .result   (result),
        .rd       (rd),
        .rd_valid (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rdn;
        logic [31:0] exp;
    } vec_t;

`ifdef MUL_HIGH_EN
    localparam int NV = 13;
`else
    localparam int NV = 7;
`endif
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and let the next edge accept it
    task automatic issue(input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r);
        funct = f; op_a = a; op_b = b; rd_in = r; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Full operation: issue, confirm quiet CALC phase, check DONE cycle
    task automatic run_op(input int idx, input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
        int early;
        early = 0;
        issue(f, a, b, r);
        chk("calc_busy_rd", 32'(busy_rd), 32'(r));
        chk("calc_ready", 32'(ready), 32'd0);
        for (int i = 1; i < 32; i++) begin
            step();
            if (rd_valid || ready) early++;
        end
        chk("calc_no_early_done", 32'(early), 32'd0);
        step();
        chk("done_ready", 32'(ready), 32'd1);
        chk("done_rd_valid", 32'(rd_valid), (r != 5'd0) ? 32'd1 : 32'd0);
        chk("done_busy_rd", 32'(busy_rd), 32'd0);
        if (r != 5'd0) begin
            chk("done_result", result, exp);
            chk("done_rd", 32'(rd), 32'(r));
        end
        step();
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_rd_valid", 32'(rd_valid), 32'd0);
        $display("op %0d funct=%0d a=%h b=%h rd=%0d result=%h expected=%h",
                 idx, f, a, b, r, result, exp);
    endtask

    // Watch a window of cycles and count any strobe
    task automatic quiet(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (rd_valid) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        int gap;
        int seen;

        vecs[0] = '{2'd0, 32'd7,        32'd6,        5'd5,  32'd42};
        vecs[1] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000001};
        vecs[2] = '{2'd0, 32'h12345678, 32'h00000010, 5'd31, 32'h23456780};
        vecs[3] = '{2'd0, 32'h80000000, 32'd2,        5'd2,  32'h00000000};
        vecs[4] = '{2'd0, 32'h0000FFFF, 32'h0000FFFF, 5'd3,  32'hFFFE0001};
        vecs[5] = '{2'd0, 32'd0,        32'd5,        5'd0,  32'd0};
`ifdef MUL_HIGH_EN
        vecs[6]  = '{2'd1, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000};
        vecs[7]  = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE};
        vecs[8]  = '{2'd2, 32'hFFFFFFFF, 32'd2,        5'd7,  32'hFFFFFFFF};
        vecs[9]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'h00000000};
        vecs[10] = '{2'd1, 32'h80000000, 32'd1,        5'd10, 32'hFFFFFFFF};
        vecs[11] = '{2'd3, 32'h80000000, 32'd4,        5'd11, 32'h00000002};
        vecs[12] = '{2'd2, 32'h00000003, 32'hFFFFFFFF, 5'd12, 32'h00000002};
`else
        // funct ignored: a MULH request yields the low product word
        vecs[6] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000001};
`endif

        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        op_a = '0; op_b = '0; funct = '0; rd_in = '0;
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_busy_rd", 32'(busy_rd), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            run_op(i, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].rdn, vecs[i].exp);
        end

        // Flush at CALC cycle 10, then a normal operation
        issue(2'd0, 32'd9, 32'd9, 5'd13);
        for (int i = 1; i < 10; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy_rd", 32'(busy_rd), 32'd0);
        chk("flush_ready", 32'(ready), 32'd1);
        quiet("flush_no_strobe", 40);
        $display("seq flush: busy_rd=%0d ready=%0d", busy_rd, ready);
        run_op(100, 2'd0, 32'd11, 32'd13, 5'd14, 32'd143);

        // Start pulses during CALC are ignored
        issue(2'd0, 32'd5, 32'd5, 5'd15);
        for (int i = 1; i < 32; i++) begin
            if (i == 5) begin
                op_a = 32'd100; op_b = 32'd100; rd_in = 5'd16; start = 1'b1;
            end
            step();
            start = 1'b0;
        end
        chk("calcstart_busy_rd", 32'(busy_rd), 32'd15);
        step();
        chk("calcstart_rd_valid", 32'(rd_valid), 32'd1);
        chk("calcstart_result", result, 32'd25);
        chk("calcstart_rd", 32'(rd), 32'd15);
        $display("seq start-in-calc: result=%h rd=%0d", result, rd);

        // Back-to-back issue from DONE: 7x6 rd5, then 3x4 rd9
        issue(2'd0, 32'd7, 32'd6, 5'd5);
        seen = 0;
        for (int i = 0; i < 100 && !rd_valid; i++) step();
        chk("b2b_first_strobe", 32'(rd_valid), 32'd1);
        chk("b2b_first_result", result, 32'd42);
        funct = 2'd0; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd9; start = 1'b1;
        step();
        start = 1'b0;
        gap = 1;
        for (int i = 0; i < 100 && !rd_valid; i++) begin
            step();
            gap++;
        end
        chk("b2b_gap", 32'(gap), 32'd33);
        chk("b2b_result", result, 32'd12);
        chk("b2b_rd", 32'(rd), 32'd9);
        $display("seq back-to-back: gap=%0d result=%h rd=%0d", gap, result, rd);
        step();

        // Flush and start together in DONE: start is dropped
        issue(2'd0, 32'd2, 32'd2, 5'd17);
        for (int i = 0; i < 100 && !rd_valid; i++) step();
        op_a = 32'd8; rd_in = 5'd18; start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        chk("flushstart_busy_rd", 32'(busy_rd), 32'd0);
        chk("flushstart_ready", 32'(ready), 32'd1);
        quiet("flushstart_no_strobe", 40);
        $display("seq flush+start: busy_rd=%0d ready=%0d", busy_rd, ready);

        // Reset at CALC cycle 20
        issue(2'd0, 32'd6, 32'd7, 5'd19);
        for (int i = 1; i < 20; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_busy_rd", 32'(busy_rd), 32'd0);
        chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_rd", 32'(rd), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet("midrst_no_strobe", 40);
        $display("seq mid-reset: ready=%0d busy_rd=%0d", ready, busy_rd);
        run_op(200, 2'd0, 32'd3, 32'd4, 5'd9, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
